seq_detector_prog: RTL and testbench

//  Runtime-programmable serial bit-pattern detector. It generalises the fixed 4-bit

---
 rtl/seqdet_pkg.sv | 22 ++
 rtl/seqdet_history.sv | 30 +++
 rtl/seq_detector_prog.sv | 96 +++++++++
 tb/tb_seq_detector_prog.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seqdet_pkg;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  // Widest mask the helper can build; MAX_LEN must not exceed this.
  localparam int unsigned MASK_W = 32;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seqdet_history.sv
// Serial history shift register (newest bit in hist[0]) with a saturating fill count.
module seqdet_history #(
  parameter int MAX_LEN = 8,
  parameter int FILL_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift,
  input  logic               fill_clr,
  input  logic               x,
  output logic [MAX_LEN-1:0] hist,
  output logic [FILL_W-1:0]  fill
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= {hist[MAX_LEN-2:0], x};
      // Non-overlapping match restarts the count; stale hist bits are masked by fill.
      if (fill_clr)
        fill <= '0;
      else if (fill != FILL_W'(MAX_LEN))
        fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with registered 1-cycle match pulse z.
// Optional saturating match counter built when SEQDET_COUNT_EN is defined.
module seq_detector_prog
  import seqdet_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               in_valid,
  input  logic               x,
  output logic               z,
  output logic               armed
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  state_e             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] next_hist;
  logic [LEN_W:0]     fill_inc;
  logic [MASK_W-1:0]  mask;
  logic               sample;
  logic               len_legal;
  logic               match;

  // A config load in the same cycle wins over the data bit.
  assign sample    = in_valid && !cfg_load;
  assign len_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  always_comb begin
    next_hist = (hist << 1) | MAX_LEN'(x);
    fill_inc  = {1'b0, fill} + 1'b1;
    mask      = len_mask(32'(len_q));
    match     = (state == S_RUN) && sample
             && (fill_inc >= {1'b0, len_q})
             && ((MASK_W'(next_hist) & mask) == (MASK_W'(pat_q) & mask));
  end

  seqdet_history #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_history (
    .clk      (clk),
    .reset    (reset),
    .clear    (cfg_load),
    .shift    (sample),
    .fill_clr (match && !overlap_q),
    .x        (x),
    .hist     (hist),
    .fill     (fill)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      z         <= 1'b0;
      armed     <= 1'b0;
    end else if (cfg_load) begin
      pat_q     <= pat;
      len_q     <= pat_len;
      overlap_q <= overlap;
      z         <= 1'b0;
      state     <= len_legal ? S_RUN : S_IDLE;
      armed     <= len_legal;
    end else begin
      z <= match;
    end
  end

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || cfg_load)
      match_cnt <= '0;
    else if (z && (match_cnt != '1))
      match_cnt <= match_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog; expected z/armed/match_cnt come from a
// bit-queue reference model and are queued per driven cycle, popped after the edge.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
`ifdef SEQDET_COUNT_EN
  localparam int CNT_W   = 2;
`else
  localparam int CNT_W   = 8;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] pat = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic               overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               x = 1'b0;
  logic               z;
  logic               armed;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]   match_cnt;
`endif

  always #5 clk = ~clk;

  seq_detector_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_load (cfg_load),
    .pat      (pat),
    .pat_len  (pat_len),
    .overlap  (overlap),
    .in_valid (in_valid),
    .x        (x),
    .z        (z),
    .armed    (armed)
`ifdef SEQDET_COUNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

  typedef struct packed {
    logic       z;
    logic       armed;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_run = 0;
  bit   [7:0] m_pat = '0;
  int         m_len = 0;
  bit         m_ov = 0;
  bit         m_bits[$];
  int         m_fill = 0;
  bit         m_z = 0;
  int         m_cnt = 0;

  // Current configuration presented on the cfg inputs
  logic [7:0] c_pat = '0;
  logic [3:0] c_len = '0;
  logic       c_ov = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model(input bit rs, input bit ld, input bit v, input bit xb);
    bit m;
    int cnt_max;
    cnt_max = (1 << CNT_W) - 1;
    if (rs) begin
      m_run = 0; m_pat = '0; m_len = 0; m_ov = 0;
      m_bits.delete(); m_fill = 0; m_z = 0; m_cnt = 0;
    end else if (ld) begin
      m_pat = c_pat; m_len = int'(c_len); m_ov = c_ov;
      m_run = (m_len >= 1) && (m_len <= MAX_LEN);
      m_bits.delete(); m_fill = 0; m_z = 0; m_cnt = 0;
    end else begin
      if (m_z && m_cnt < cnt_max) m_cnt++;
      m = 0;
      if (v) begin
        m_bits.push_back(xb);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        if (m_fill < MAX_LEN) m_fill++;
        if (m_run && m_fill >= m_len) begin
          m = 1;
          // pat[0] pairs with the newest bit, pat[len-1] with the oldest
          for (int i = 0; i < m_len; i++)
            if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) m = 0;
        end
        if (m && !m_ov) m_fill = 0;
      end
      m_z = m;
    end
  endtask

  task automatic step(input bit rs, input bit ld, input bit v, input bit xb);
    exp_t e;
    exp_t got;
    reset    = rs;
    cfg_load = ld;
    pat      = c_pat;
    pat_len  = c_len;
    overlap  = c_ov;
    in_valid = v;
    x        = xb;
    model(rs, ld, v, xb);
    e.z     = m_z;
    e.armed = m_run;
    e.cnt   = 8'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("z", 32'(z), 32'(got.z));
      check("armed", 32'(armed), 32'(got.armed));
`ifdef SEQDET_COUNT_EN
      check("match_cnt", 32'(match_cnt), 32'(got.cnt));
`endif
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    c_pat = p; c_len = l; c_ov = ov;
    step(0, 1, 0, 0);
  endtask

  // '1'/'0' send a valid bit, '_' is an in_valid=0 cycle
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "_") step(0, 0, 0, 0);
      else step(0, 0, 1, s[i] == "1");
    end
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    check("reset_z", 32'(z), 32'd0);
    check("reset_armed", 32'(armed), 32'd0);

    load(8'b1011, 4, 1);
    send("1011011__");

    load(8'b1011, 4, 0);
    send("1011011__");
    load(8'b1011, 4, 0);
    send("10111011__");

    load(8'b1011, 4, 1);
    send("10__11__");

    load(8'b1011, 0, 1);
    send("1111011011");
    load(8'b0001, 1, 1);
    send("1101_1001__");

    load(8'b1011, 4, 1);
    send("101");
    step(1, 0, 1, 1);
    send("1__");
    load(8'b1011, 4, 1);
    send("101");
    step(0, 1, 1, 1);
    send("1011__");

    load(8'b1011_0110, 8, 1);
    send("10110110110110__");
    load(8'b0000_0101, 9, 1);
    send("0101010");

    load(8'b0000_0001, 1, 1);
    send("111111___");
    load(8'b0000_0001, 1, 1);
    send("__");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0)
        load(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom));
      else if ($urandom_range(0, 99) == 0)
        step(1, $urandom_range(0, 1) == 1, 1, 1'($urandom));
      else
        step(0, 0, $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
